// File: rtl/spill_tracker.sv
// ============================================================================
// Module   : spill_tracker
// Purpose  : Turns the cleaned beam-live level into per-spill events:
//            start/end pulses, a wrapping spill id, on/off duration
//            measurements, a stuck-on watchdog and a one-entry spill record
//            published over a valid/ready handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            live_in, enable     - cleaned live level, spill arming
//            spill_active/start/end, spill_id - spill status and events
//            rec_valid/ready, rec_id, rec_on_len, rec_off_len, rec_flags
//                                - completed-spill record (flags[0] timeout,
//                                  flags[1] previous record overwritten)
//            stat_timeouts, stat_overruns (only with SPILL_TRACKER_STATS_EN)
// Options  : `define SPILL_TRACKER_STATS_EN adds saturating 16-bit timeout
//            and overrun event counters as extra output ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spill_tracker #(
    parameter int              CNT_W         = 32,
    parameter int              ID_W          = 16,
    parameter longint unsigned MAX_ON_PERIOD = 625000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             live_in,
    input  logic             enable,
    output logic             spill_active,
    output logic             spill_start,
    output logic             spill_end,
    output logic [ID_W-1:0]  spill_id,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [ID_W-1:0]  rec_id,
    output logic [CNT_W-1:0] rec_on_len,
    output logic [CNT_W-1:0] rec_off_len,
    output logic [1:0]       rec_flags
`ifdef SPILL_TRACKER_STATS_EN
    ,
    output logic [15:0]      stat_timeouts,
    output logic [15:0]      stat_overruns
`endif
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_max_on  = MAX_ON_PERIOD[CNT_W-1:0];

    typedef enum logic [1:0] {
        ST_WAIT_OFF = 2'd0,
        ST_OFF      = 2'd1,
        ST_ON       = 2'd2,
        ST_TIMEOUT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               live_q;
    // live_q is forced to 0 by reset; that value is not a real observation
    // of the beam, so WAIT_OFF must not treat it as a low level.
    logic               live_vld_q;
    logic [CNT_W-1:0]   off_cnt_q, off_cnt_d;
    logic [CNT_W-1:0]   on_cnt_q, on_cnt_d;
    logic [CNT_W-1:0]   off_len_q, off_len_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               active_q, active_d;
    logic               start_q, start_d;
    logic               end_q, end_d;
    logic               rec_valid_q, rec_valid_d;
    logic [ID_W-1:0]    rec_id_q, rec_id_d;
    logic [CNT_W-1:0]   rec_on_q, rec_on_d;
    logic [CNT_W-1:0]   rec_off_q, rec_off_d;
    logic [1:0]         rec_flags_q, rec_flags_d;

    logic               w_new_rec;
    logic               w_timeout;
    logic               w_xfer;
    logic               w_overrun;

    // ------------------------------------------------------------------
    // Spill state machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        off_cnt_d = off_cnt_q;
        on_cnt_d  = on_cnt_q;
        off_len_d = off_len_q;
        id_d      = id_q;
        active_d  = 1'b0;
        start_d   = 1'b0;
        end_d     = 1'b0;
        w_new_rec = 1'b0;
        w_timeout = 1'b0;

        case (state_q)
            ST_WAIT_OFF: begin
                if (live_vld_q && !live_q) begin
                    state_d   = ST_OFF;
                    off_cnt_d = CNT_W'(1);
                end
            end
            ST_OFF: begin
                if (!live_q) begin
                    off_cnt_d = (off_cnt_q == c_cnt_max) ? off_cnt_q
                                                         : off_cnt_q + CNT_W'(1);
                end else if (enable) begin
                    state_d   = ST_ON;
                    start_d   = 1'b1;
                    active_d  = 1'b1;
                    id_d      = id_q + ID_W'(1);
                    off_len_d = off_cnt_q;
                    on_cnt_d  = CNT_W'(1);
                end else begin
                    // Rise while disarmed: wait for a fresh low gap.
                    state_d = ST_WAIT_OFF;
                end
            end
            ST_ON: begin
                if (live_q) begin
                    if (on_cnt_q >= c_max_on) begin
                        state_d   = ST_TIMEOUT;
                        end_d     = 1'b1;
                        w_new_rec = 1'b1;
                        w_timeout = 1'b1;
                    end else begin
                        active_d = 1'b1;
                        on_cnt_d = (on_cnt_q == c_cnt_max) ? on_cnt_q
                                                           : on_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d   = ST_OFF;
                    end_d     = 1'b1;
                    w_new_rec = 1'b1;
                    off_cnt_d = CNT_W'(1);
                end
            end
            ST_TIMEOUT: begin
                if (!live_q) begin
                    state_d   = ST_OFF;
                    off_cnt_d = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT_OFF;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // One-entry record slot; a new record replaces an untaken one and is
    // marked as overrun, unless the old one transfers in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_xfer      = rec_valid_q & rec_ready;
        w_overrun   = w_new_rec & rec_valid_q & ~w_xfer;
        rec_valid_d = rec_valid_q & ~w_xfer;
        rec_id_d    = rec_id_q;
        rec_on_d    = rec_on_q;
        rec_off_d   = rec_off_q;
        rec_flags_d = rec_flags_q;
        if (w_new_rec) begin
            rec_valid_d = 1'b1;
            rec_id_d    = id_q;
            rec_on_d    = on_cnt_q;
            rec_off_d   = off_len_q;
            rec_flags_d = {w_overrun, w_timeout};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_OFF;
            live_q      <= 1'b0;
            live_vld_q  <= 1'b0;
            off_cnt_q   <= '0;
            on_cnt_q    <= '0;
            off_len_q   <= '0;
            id_q        <= '0;
            active_q    <= 1'b0;
            start_q     <= 1'b0;
            end_q       <= 1'b0;
            rec_valid_q <= 1'b0;
            rec_id_q    <= '0;
            rec_on_q    <= '0;
            rec_off_q   <= '0;
            rec_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            live_q      <= live_in;
            live_vld_q  <= 1'b1;
            off_cnt_q   <= off_cnt_d;
            on_cnt_q    <= on_cnt_d;
            off_len_q   <= off_len_d;
            id_q        <= id_d;
            active_q    <= active_d;
            start_q     <= start_d;
            end_q       <= end_d;
            rec_valid_q <= rec_valid_d;
            rec_id_q    <= rec_id_d;
            rec_on_q    <= rec_on_d;
            rec_off_q   <= rec_off_d;
            rec_flags_q <= rec_flags_d;
        end
    end

    assign spill_active = active_q;
    assign spill_start  = start_q;
    assign spill_end    = end_q;
    assign spill_id     = id_q;
    assign rec_valid    = rec_valid_q;
    assign rec_id       = rec_id_q;
    assign rec_on_len   = rec_on_q;
    assign rec_off_len  = rec_off_q;
    assign rec_flags    = rec_flags_q;

`ifdef SPILL_TRACKER_STATS_EN
    logic [15:0] stat_to_q, stat_to_d;
    logic [15:0] stat_ov_q, stat_ov_d;

    always_comb begin
        stat_to_d = stat_to_q;
        stat_ov_d = stat_ov_q;
        if (w_timeout && (stat_to_q != 16'hFFFF)) begin
            stat_to_d = stat_to_q + 16'd1;
        end
        if (w_overrun && (stat_ov_q != 16'hFFFF)) begin
            stat_ov_d = stat_ov_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_to_q <= '0;
            stat_ov_q <= '0;
        end else begin
            stat_to_q <= stat_to_d;
            stat_ov_q <= stat_ov_d;
        end
    end

    assign stat_timeouts = stat_to_q;
    assign stat_overruns = stat_ov_q;
`endif

endmodule

`default_nettype wire
